// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: branch funct3 encodings, BHT counter type and
// helpers used by the branch predictor.
package riscv_pkg;

    // RV32I conditional branch funct3 encodings
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_instr;

    // 2-bit saturating branch history counter
    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_SNT = 2'b00;  // strongly not-taken
    localparam bht_ctr_t BHT_WNT = 2'b01;  // weakly not-taken
    localparam bht_ctr_t BHT_WT  = 2'b10;  // weakly taken
    localparam bht_ctr_t BHT_ST  = 2'b11;  // strongly taken

    // Operands are sign-extended to this width before comparison.
    // Sign extension preserves both signed and unsigned ordering, so one
    // fixed-width helper serves any XLEN up to this size.
    localparam int BR_OPND_W = 64;

    // Evaluate a branch condition; the two reserved funct3 codes yield 0.
    function automatic logic branch_cond(
        input logic [2:0]           funct3,
        input logic [BR_OPND_W-1:0] rs1,
        input logic [BR_OPND_W-1:0] rs2
    );
        logic res;
        res = 1'b0;
        case (branch_instr'(funct3))
            BR_BEQ:  res = (rs1 == rs2);
            BR_BNE:  res = (rs1 != rs2);
            BR_BLT:  res = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  res = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: res = (rs1 <  rs2);
            BR_BGEU: res = (rs1 >= rs2);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Next counter state after a resolved outcome, saturating at both ends.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            nxt = (ctr == BHT_ST)  ? BHT_ST  : bht_ctr_t'(ctr + 2'b01);
        end else begin
            nxt = (ctr == BHT_SNT) ? BHT_SNT : bht_ctr_t'(ctr - 2'b01);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read
// port (no write bypass) and one saturating update port, synchronous reset.
module bht_table
    import riscv_pkg::*;
#(
    parameter int       DEPTH = 64,
    parameter bht_ctr_t INIT  = BHT_WNT,
    localparam int      IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_ctr_t ctr_r [DEPTH];

    // Read returns the stored value; an update in the same cycle shows next cycle
    assign rd_ctr = ctr_r[rd_idx];

    // Reinitialise every counter on reset, otherwise apply the saturating update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= INIT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= bht_next(ctr_r[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: fetch-stage BHT prediction plus a registered
// execute-stage resolution path (outcome, mispredict, redirect PC).
// Optional feature macro: BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
    import riscv_pkg::*;
#(
    parameter int       XLEN      = 32,
    parameter int       BHT_DEPTH = 64,
    parameter bht_ctr_t BHT_INIT  = BHT_WNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    input  logic [XLEN-1:0] pred_imm,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [31:0]     ex_instr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal,
    output logic [XLEN-1:0] res_next_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0]     pred_idx_s;
    logic [IDX_W-1:0]     ex_idx_s;
    bht_ctr_t             pred_ctr_s;
    logic [2:0]           funct3_s;
    logic                 legal_s;
    logic                 taken_s;
    logic                 mispredict_s;
    logic                 bht_wr_s;
    logic [XLEN-1:0]      next_pc_s;
    logic [BR_OPND_W-1:0] rs1_ext_s;
    logic [BR_OPND_W-1:0] rs2_ext_s;
    logic                 unused_instr_s;

    logic                 res_valid_r;
    logic                 res_taken_r;
    logic                 res_mispredict_r;
    logic                 res_illegal_r;
    logic [XLEN-1:0]      res_next_pc_r;

    // Only funct3 of the instruction word matters to branch resolution
    assign unused_instr_s = ^{ex_instr[31:15], ex_instr[11:0]};

    assign pred_idx_s = pred_pc[IDX_W+1:2];
    assign ex_idx_s   = ex_pc[IDX_W+1:2];

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .INIT  (BHT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pred_idx_s),
        .rd_ctr   (pred_ctr_s),
        .wr_en    (bht_wr_s),
        .wr_idx   (ex_idx_s),
        .wr_taken (taken_s)
    );

    // Fetch prediction: counter MSB gated by the lookup request
    always_comb begin
        pred_taken  = pred_ctr_s[1] & pred_valid;
        pred_target = pred_pc + XLEN'(32'd4);
        if (pred_taken) begin
            pred_target = pred_pc + pred_imm;
        end else begin
            pred_target = pred_pc + XLEN'(32'd4);
        end
    end

    // Execute resolution: evaluate condition, choose redirect PC, gate BHT update
    always_comb begin
        funct3_s  = ex_instr[14:12];
        legal_s   = (funct3_s != 3'b010) && (funct3_s != 3'b011);
        rs1_ext_s = BR_OPND_W'($signed(ex_rs1));
        rs2_ext_s = BR_OPND_W'($signed(ex_rs2));
        taken_s   = legal_s & branch_cond(funct3_s, rs1_ext_s, rs2_ext_s);
        if (taken_s) begin
            next_pc_s = ex_pc + ex_imm;
        end else begin
            next_pc_s = ex_pc + XLEN'(32'd4);
        end
        mispredict_s = taken_s ^ ex_pred_taken;
        bht_wr_s     = ex_valid & legal_s;
    end

    // Resolution registers; result fields hold while no branch is present
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_r      <= 1'b0;
            res_taken_r      <= 1'b0;
            res_mispredict_r <= 1'b0;
            res_illegal_r    <= 1'b0;
            res_next_pc_r    <= {XLEN{1'b0}};
        end else begin
            res_valid_r <= ex_valid;
            if (ex_valid) begin
                res_taken_r      <= taken_s;
                res_mispredict_r <= mispredict_s;
                res_illegal_r    <= ~legal_s;
                res_next_pc_r    <= next_pc_s;
            end
        end
    end

    assign res_valid      = res_valid_r;
    assign res_taken      = res_taken_r;
    assign res_mispredict = res_mispredict_r;
    assign res_illegal    = res_illegal_r;
    assign res_next_pc    = res_next_pc_r;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating counts of legal resolved branches and their mispredicts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else if (ex_valid && legal_s) begin
            if (stat_branches_r != 32'hFFFF_FFFF) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule
